// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: command and response handshake bundle for alu_cmd_issuer.
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op : command channel into the issuer
//   rsp_valid/rsp_ready/rsp_data/rsp_op/rsp_err : response channel out of the issuer
//   master : producer of commands / consumer of responses
//   slave  : the issuer itself
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_op, rsp_err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands in a DEPTH-entry FIFO, drives one command
// at a time onto registered operand/opcode lines of an external combinational
// ALU, captures the result one cycle later and holds it as a response until
// the consumer takes it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : command channel in, response channel out
//   alu_op_a/b, alu_op : registered operands/opcode to the ALU
//   alu_result      : combinational ALU result for the driven operands
//   cmd_count       : FIFO occupancy, 0..DEPTH
module alu_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_cmd_issuer_if.slave        bus,
    output logic [7:0]             alu_op_a,
    output logic [7:0]             alu_op_b,
    output logic [2:0]             alu_op,
    input  logic [7:0]             alu_result,
    output logic [$clog2(DEPTH):0] cmd_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

    state_t        state_q, state_d;
    cmd_t          mem_q [DEPTH];
    cmd_t          mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    alu_a_q, alu_a_d;
    logic [7:0]    alu_b_q, alu_b_d;
    logic [2:0]    alu_opc_q, alu_opc_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [2:0]    rsp_op_q, rsp_op_d;
    logic          rsp_err_q, rsp_err_d;

    logic cmd_ready_w;
    logic push;
    logic pop;
    logic fifo_empty;
    logic illegal;
    cmd_t head;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign cmd_ready_w = (count_q != CW'(DEPTH));
    assign push        = bus.cmd_valid && cmd_ready_w;
    assign fifo_empty  = (count_q == '0);
    assign head        = mem_q[rd_ptr_q];
    assign illegal     = (alu_opc_q >= 3'd6);

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_opc_d   = alu_opc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                // ALU has had a full cycle on the registered operands.
                rsp_valid_d = 1'b1;
                rsp_op_d    = alu_opc_q;
                rsp_err_d   = illegal;
                rsp_data_d  = illegal ? 8'h00 : alu_result;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Chain straight into the next command to sustain 1 rsp / 2 cycles.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            alu_a_d   = head.a;
            alu_b_d   = head.b;
            alu_opc_d = head.op;
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // Storage needs no reset: occupancy and pointers gate every read.
        mem_q <= mem_d;
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_opc_q   <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_op_q    <= 3'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_opc_q   <= alu_opc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_w;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_op_a      = alu_a_q;
    assign alu_op_b      = alu_b_q;
    assign alu_op        = alu_opc_q;
    assign cmd_count     = count_q;
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: scoreboard bench for alu_cmd_issuer. Accepted commands push
// their expected response into a queue; an independent monitor pops and compares
// on every response handshake and checks that stalled responses hold steady.
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_issuer_if bus_if ();
    logic [7:0]             alu_op_a, alu_op_b, alu_result;
    logic [2:0]             alu_op;
    logic [$clog2(DEPTH):0] cmd_count;

    alu_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .alu_op_a   (alu_op_a),
        .alu_op_b   (alu_op_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .cmd_count  (cmd_count)
    );

    // Team ALU; illegal opcodes return a nonzero junk value the issuer must mask.
    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            3'd0:    alu_result = alu_op_a + alu_op_b;
            3'd1:    alu_result = alu_op_a - alu_op_b;
            3'd2:    alu_result = alu_op_a & alu_op_b;
            3'd3:    alu_result = alu_op_a | alu_op_b;
            3'd4:    alu_result = alu_op_a ^ alu_op_b;
            3'd5:    alu_result = ~alu_op_a;
            default: alu_result = alu_op_a ^ alu_op_b ^ 8'h5A;
        endcase
    end

    typedef struct {
        int data;
        int op;
        int err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_hs = 0;
    int   last_acc = 0;
    int   last_hs = -1;
    bit   chk_gap = 1'b0;
    bit   rand_rdy = 1'b0;

    // Reference model: response from the opcode table using integer arithmetic.
    function automatic rsp_t model(input int a, input int b, input int op);
        rsp_t r;
        r.op  = op;
        r.err = (op > 5) ? 1 : 0;
        case (op)
            0:       r.data = (a + b) % 256;
            1:       r.data = (a - b + 256) % 256;
            2:       r.data = a & b;
            3:       r.data = a | b;
            4:       r.data = a ^ b;
            5:       r.data = 255 - a;
            default: r.data = 0;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus_if.rsp_ready = 1'($urandom_range(0, 1));
    end

    // Monitor / scoreboard
    initial begin : monitor
        bit   stall;
        int   h_data, h_op, h_err;
        rsp_t e;
        stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", int'(bus_if.rsp_valid), 1);
                    check("hold_data", int'(bus_if.rsp_data), h_data);
                    check("hold_op", int'(bus_if.rsp_op), h_op);
                    check("hold_err", int'(bus_if.rsp_err), h_err);
                end
                if (bus_if.rsp_valid && bus_if.rsp_ready) begin
                    n_hs++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected data=%0h op=%0d required=no response", bus_if.rsp_data, bus_if.rsp_op);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", int'(bus_if.rsp_data), e.data);
                        check("rsp_op", int'(bus_if.rsp_op), e.op);
                        check("rsp_err", int'(bus_if.rsp_err), e.err);
                    end
                    if (chk_gap && last_hs >= 0) check("rsp_gap", cyc - last_hs, 2);
                    last_hs = cyc;
                    stall = 1'b0;
                end else if (bus_if.rsp_valid) begin
                    stall  = 1'b1;
                    h_data = int'(bus_if.rsp_data);
                    h_op   = int'(bus_if.rsp_op);
                    h_err  = int'(bus_if.rsp_err);
                end else begin
                    stall = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1. Leaves cmd_valid asserted.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input int bound, output bit ok);
        bus_if.cmd_a     = a;
        bus_if.cmd_b     = b;
        bus_if.cmd_op    = op;
        bus_if.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus_if.cmd_ready) begin
                exp_q.push_back(model(int'(a), int'(b), int'(op)));
                last_acc = cyc + 1;
                n_acc++;
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_ok(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        bit ok;
        send(a, b, op, 60, ok);
        check("cmd_accept", int'(ok), 1);
    endtask

    task automatic wait_drain();
        bit done;
        bus_if.cmd_valid = 1'b0;
        bus_if.rsp_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus_if.rsp_valid) done = 1'b1;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        bit   ok6, found;
        int   lat, acc0, hs0;
        logic [7:0] a6, b6;
        logic [2:0] op6;

        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_a     = 8'h00;
        bus_if.cmd_b     = 8'h00;
        bus_if.cmd_op    = 3'd0;
        bus_if.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", int'(bus_if.rsp_valid), 0);
        check("rst_cmd_count", int'(cmd_count), 0);
        check("rst_rsp_data", int'(bus_if.rsp_data), 0);
        check("rst_rsp_op", int'(bus_if.rsp_op), 0);
        check("rst_rsp_err", int'(bus_if.rsp_err), 0);
        check("rst_alu_a", int'(alu_op_a), 0);
        check("rst_alu_b", int'(alu_op_b), 0);
        check("rst_alu_op", int'(alu_op), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", int'(bus_if.cmd_ready), 1);
        @(posedge clk);
        #1;

        // ADD with wrap, idle latency
        bus_if.rsp_ready = 1'b1;
        send_ok(8'hF0, 8'h20, 3'd0);
        bus_if.cmd_valid = 1'b0;
        found = 1'b0;
        lat = -1;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus_if.rsp_valid) begin
                found = 1'b1;
                lat = cyc - last_acc;
                check("add_data", int'(bus_if.rsp_data), 8'h10);
            end
        end
        check("idle_latency", lat, 2);
        wait_drain();

        // SUB borrow wrap then NOT, in order
        send_ok(8'h05, 8'h07, 3'd1);
        send_ok(8'h3C, 8'h00, 3'd5);
        wait_drain();

        // Illegal opcode
        send_ok(8'hFF, 8'hFF, 3'd6);
        wait_drain();

        // Backpressure: 6 back-to-back, 5 fit
        bus_if.rsp_ready = 1'b0;
        acc0 = n_acc;
        for (int k = 0; k < 5; k++)
            send_ok(8'($urandom), 8'($urandom), 3'($urandom_range(0, 5)));
        a6 = 8'($urandom); b6 = 8'($urandom); op6 = 3'($urandom_range(0, 5));
        send(a6, b6, op6, 6, ok6);
        check("sixth_refused", int'(ok6), 0);
        check("accepted_5", n_acc - acc0, 5);
        check("full_count", int'(cmd_count), DEPTH);
        check("full_ready", int'(bus_if.cmd_ready), 0);

        // Full FIFO with simultaneous pop and cmd_valid
        last_hs = -1;
        chk_gap = 1'b1;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        check("full_pop_ready", int'(bus_if.cmd_ready), 0);
        check("full_pop_count", int'(cmd_count), DEPTH);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_pop_count", int'(cmd_count), DEPTH - 1);
        check("after_pop_ready", int'(bus_if.cmd_ready), 1);
        exp_q.push_back(model(int'(a6), int'(b6), int'(op6)));
        n_acc++;
        @(posedge clk);
        #1;
        bus_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("late_push_count", int'(cmd_count), DEPTH);
        @(posedge clk);
        #1;
        wait_drain();
        chk_gap = 1'b0;

        // Reset while in RESP with 3 queued
        bus_if.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_ok(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
        bus_if.cmd_valid = 1'b0;
        check("pre_rst_count", int'(cmd_count), 3);
        check("pre_rst_valid", int'(bus_if.rsp_valid), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", int'(bus_if.rsp_valid), 0);
        check("mid_rst_count", int'(cmd_count), 0);
        hs0 = n_hs;
        repeat (12) @(negedge clk);
        check("mid_rst_no_rsp", n_hs - hs0, 0);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 150; k++) begin
            int idle;
            send_ok(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            idle = $urandom_range(0, 2);
            if (idle > 0) begin
                bus_if.cmd_valid = 1'b0;
                repeat (idle) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        rand_rdy = 1'b0;
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The module SHALL have one parameter: DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 The module SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  issuer can accept a command.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT; 6 and 7 illegal.
REQ-010 alu_op_a  output  8  registered operand A to the combinational ALU.
REQ-011 alu_op_b  output  8  registered operand B to the combinational ALU.
REQ-012 alu_op  output  3  registered opcode to the ALU.
REQ-013 alu_result  input  8  combinational ALU result for the current alu_op_a/alu_op_b/alu_op.
REQ-014 rsp_valid  output  1  response held.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_data  output  8  captured result.
REQ-017 rsp_op  output  3  opcode echo for the response.
REQ-018 rsp_err  output  1  response is for an illegal opcode.
REQ-019 cmd_count  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Function
REQ-020 Command transfer SHALL occur on a clock edge where cmd_valid && cmd_ready; {cmd_a, cmd_b, cmd_op} is pushed to the FIFO tail.
REQ-021 cmd_ready SHALL equal (cmd_count != DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-022 Push and pop in the same cycle SHALL leave cmd_count unchanged; read/write pointers wrap modulo DEPTH.
REQ-023 FSM states SHALL be IDLE, DRIVE, RESP.
REQ-024 IDLE: if FIFO non-empty, pop head, load alu_op_a/alu_op_b/alu_op, go to DRIVE; else stay.
REQ-025 DRIVE (exactly one cycle): at its ending edge, capture rsp_data = alu_result, rsp_op = alu_op, rsp_err = (alu_op >= 6), set rsp_valid, go to RESP.
REQ-026 For an illegal opcode, rsp_data SHALL be 8'h00 regardless of alu_result; the opcode is still driven to the ALU.
REQ-027 RESP: rsp_valid, rsp_data, rsp_op and rsp_err SHALL hold stable until rsp_valid && rsp_ready.
REQ-028 On that edge, rsp_valid SHALL clear; if the FIFO is non-empty, pop and go straight to DRIVE, else go to IDLE.
REQ-029 Latency SHALL be 2 cycles when idle: a command accepted at edge N with the FIFO empty gives rsp_valid high after edge N+2.
REQ-030 Sustained throughput SHALL be one response per 2 cycles with rsp_ready held high.
REQ-031 alu_op_a/alu_op_b/alu_op SHALL hold their last issued values outside DRIVE.
REQ-032 Arithmetic SHALL be 8-bit modulo 2^8: ADD and SUB wrap, with no carry or borrow output.

Reset
REQ-033 While rst is high at a rising edge, the FIFO SHALL be flushed (pointers 0, cmd_count 0) and FSM set to IDLE.
REQ-034 The same reset SHALL set rsp_valid 0, rsp_data 8'h00, rsp_op 0, rsp_err 0, and alu_op_a/alu_op_b/alu_op 0.
REQ-035 cmd_ready SHALL be 1 in the cycle after reset is released.
REQ-036 Reset mid-operation (DRIVE or RESP) SHALL discard the in-flight command, its response and all queued commands; none are later emitted.

Verification (alu_result driven by the team's 8-bit ALU)
REQ-037 ADD a=0xF0, b=0x20, rsp_ready=1 -> rsp_data=0x10, rsp_err=0, rsp_valid rises exactly 2 cycles after acceptance.
REQ-038 SUB a=0x05, b=0x07, then NOT a=0x3C -> responses in order 0xFE then 0xC3, rsp_op 1 then 5.
REQ-039 cmd_op=6, a=0xFF, b=0xFF -> rsp_data=0x00, rsp_err=1, rsp_op=6.
REQ-040 rsp_ready=0, 6 back-to-back commands (DEPTH=4) -> 5 accepted (1 in RESP plus 4 queued), cmd_ready=0, cmd_count=4, rsp_data stable. Releasing rsp_ready -> all 5 emitted in order, 2 cycles apart.
REQ-041 Full FIFO with simultaneous pop and cmd_valid -> no push that cycle; cmd_count goes 4->3; the command is accepted on the next edge.
REQ-042 rst asserted for 1 cycle while in RESP with 3 queued -> rsp_valid=0 next cycle, cmd_count=0, no further responses without new commands.
